// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// the default BTB depth.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam int unsigned DEFAULT_ENTRIES = 16;

endpackage

// File: rtl/branch_predictor_sat_cnt2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_cnt2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] next_cnt
);

    always_comb begin
        next_cnt = cnt;
        if (taken) begin
            if (cnt != ST) next_cnt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) next_cnt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, registered lookup and
// a saturating misprediction counter.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = DEFAULT_ENTRIES,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic        if_stall,
    input  logic [31:0] if_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_is_jmp,
    input  logic [31:0] ex_pc,
    input  logic        ex_act_taken,
    input  logic [31:0] ex_act_target,
    input  logic        ex_flush_req,
    output logic [31:0] mispred_cnt
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic        pred_valid_q;
    logic        pred_taken_q;
    logic [31:0] pred_target_q;
    logic [31:0] mispred_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Lookup path reads the arrays as they stand before this edge's update.
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             lk_hit;
    logic             lk_taken;
    logic [31:0]      lk_target;

    assign if_idx    = if_pc[IDX_W+1:2];
    assign if_tag    = if_pc[31:IDX_W+2];
    assign lk_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign lk_taken  = lk_hit && cnt_q[if_idx][1];
    assign lk_target = lk_taken ? target_q[if_idx] : if_pc + 32'd4;

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [1:0]       ex_cnt_next;

    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    sat_cnt2 u_sat_cnt2 (
        .cnt      (cnt_q[ex_idx]),
        .taken    (ex_act_taken),
        .next_cnt (ex_cnt_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) cnt_q[i] <= WNT;
        end else if (ex_is_jmp) begin
            if (ex_hit) begin
                cnt_q[ex_idx] <= ex_cnt_next;
            end else if (ex_act_taken) begin
                valid_q[ex_idx] <= 1'b1;
                cnt_q[ex_idx]   <= WT;
            end
        end
    end

    // Tag and target carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (rst_n && ex_is_jmp && ex_act_taken) begin
            target_q[ex_idx] <= ex_act_target;
            if (!ex_hit) tag_q[ex_idx] <= ex_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else if (!if_stall) begin
            pred_valid_q <= if_req;
            if (if_req) begin
                pred_taken_q  <= lk_taken;
                pred_target_q <= lk_target;
            end else begin
                pred_taken_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mispred_q <= '0;
        end else if (ex_is_jmp && ex_flush_req && (mispred_q != '1)) begin
            mispred_q <= mispred_q + 32'd1;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector table plus randomized traffic checked against a simple
// behavioural model of the predictor.
module tb_branch_predictor;

    localparam int NENT = 16;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic        if_stall;
    logic [31:0] if_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_is_jmp;
    logic [31:0] ex_pc;
    logic        ex_act_taken;
    logic [31:0] ex_act_target;
    logic        ex_flush_req;
    logic [31:0] mispred_cnt;

    branch_predictor #(
        .ENTRIES (16),
        .IDX_W   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req        (if_req),
        .if_stall      (if_stall),
        .if_pc         (if_pc),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .ex_is_jmp     (ex_is_jmp),
        .ex_pc         (ex_pc),
        .ex_act_taken  (ex_act_taken),
        .ex_act_target (ex_act_target),
        .ex_flush_req  (ex_flush_req),
        .mispred_cnt   (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: one record per BTB slot.
    bit          m_valid [NENT];
    int unsigned m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_cnt   [NENT];
    bit          m_pv;
    bit          m_pt;
    logic [31:0] m_ptgt;
    bit          m_chk;
    longint      m_mis;

    typedef struct {
        logic        rst_n;
        logic        req;
        logic        stall;
        logic [31:0] pc;
        logic        jmp;
        logic [31:0] epc;
        logic        tk;
        logic [31:0] tgt;
        logic        flush;
        logic        chk;
        logic        e_pv;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic [31:0] e_mis;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int idx;
        bit hit;
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) begin
                m_valid[i] = 0;
                m_cnt[i]   = 1;
            end
            m_pv = 0; m_pt = 0; m_ptgt = 0; m_chk = 1; m_mis = 0;
            return;
        end
        if (!if_stall) begin
            m_pv = if_req;
            m_chk = if_req;
            if (if_req) begin
                idx    = (if_pc / 4) % NENT;
                hit    = m_valid[idx] && (m_tag[idx] == if_pc / (4 * NENT));
                m_pt   = hit && (m_cnt[idx] >= 2);
                m_ptgt = m_pt ? m_tgt[idx] : if_pc + 32'd4;
            end
        end
        if (ex_is_jmp) begin
            idx = (ex_pc / 4) % NENT;
            hit = m_valid[idx] && (m_tag[idx] == ex_pc / (4 * NENT));
            if (hit) begin
                m_cnt[idx] = ex_act_taken ? ((m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1)
                                          : ((m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1);
                if (ex_act_taken) m_tgt[idx] = ex_act_target;
            end else if (ex_act_taken) begin
                m_valid[idx] = 1;
                m_tag[idx]   = ex_pc / (4 * NENT);
                m_tgt[idx]   = ex_act_target;
                m_cnt[idx]   = 2;
            end
            if (ex_flush_req && m_mis < 64'hFFFF_FFFF) m_mis++;
        end
    endtask

    task automatic check_model();
        check("model pred_valid", {31'd0, pred_valid}, {31'd0, m_pv});
        if (m_chk) begin
            check("model pred_taken", {31'd0, pred_taken}, {31'd0, m_pt});
            check("model pred_target", pred_target, m_ptgt);
        end
        check("model mispred_cnt", mispred_cnt, m_mis[31:0]);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        vecs[0]  = '{0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0, 0, 32'h0,        0};
        vecs[1]  = '{1, 1, 0, 32'hBFC00000, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0, 32'hBFC00004, 0};
        vecs[2]  = '{1, 0, 0, 32'h0,        1, 32'h00400010, 1, 32'h00400100, 0, 0, 0, 0, 32'h0,        0};
        vecs[3]  = '{1, 1, 0, 32'h00400010, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h00400100, 0};
        vecs[4]  = '{1, 0, 0, 32'h0,        1, 32'h00400010, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0};
        vecs[5]  = '{1, 1, 0, 32'h00400010, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0, 32'h00400014, 0};
        vecs[6]  = vecs[4];
        vecs[7]  = vecs[5];
        vecs[8]  = vecs[2];
        vecs[9]  = vecs[5];
        vecs[10] = vecs[2];
        vecs[11] = vecs[3];
        vecs[12] = '{1, 0, 0, 32'h0,        1, 32'h00400050, 1, 32'h00400200, 0, 0, 0, 0, 32'h0,        0};
        vecs[13] = vecs[5];
        vecs[14] = '{1, 1, 0, 32'h00400050, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h00400200, 0};
        vecs[15] = '{1, 1, 0, 32'h00400080, 1, 32'h00400080, 1, 32'h00401000, 0, 1, 1, 0, 32'h00400084, 0};
        vecs[16] = '{1, 1, 0, 32'h00400080, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h00401000, 0};
        vecs[17] = '{1, 0, 0, 32'h0,        1, 32'h00400080, 1, 32'h00401000, 1, 0, 0, 0, 32'h0,        1};
        vecs[18] = '{1, 1, 0, 32'h00400080, 0, 32'h0,        0, 32'h0,        1, 1, 1, 1, 32'h00401000, 1};
        vecs[19] = '{1, 1, 0, 32'h00400010, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0, 32'h00400014, 1};
        vecs[20] = '{1, 1, 1, 32'h00400050, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0, 32'h00400014, 1};
        vecs[21] = '{1, 1, 1, 32'h00400080, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0, 32'h00400014, 1};
        vecs[22] = '{1, 1, 1, 32'hBFC00000, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0, 32'h00400014, 1};
        vecs[23] = '{1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,        1};
        vecs[24] = '{0, 1, 0, 32'h00400080, 1, 32'h00400010, 1, 32'h00400100, 1, 1, 0, 0, 32'h0,        0};
        vecs[25] = '{1, 1, 0, 32'h00400080, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0, 32'h00400084, 0};
        vecs[26] = '{1, 1, 0, 32'h00400050, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0, 32'h00400054, 0};

        rst_n = 0; if_req = 0; if_stall = 0; if_pc = 0;
        ex_is_jmp = 0; ex_pc = 0; ex_act_taken = 0; ex_act_target = 0; ex_flush_req = 0;

        for (int i = 0; i < 27; i++) begin
            rst_n         = vecs[i].rst_n;
            if_req        = vecs[i].req;
            if_stall      = vecs[i].stall;
            if_pc         = vecs[i].pc;
            ex_is_jmp     = vecs[i].jmp;
            ex_pc         = vecs[i].epc;
            ex_act_taken  = vecs[i].tk;
            ex_act_target = vecs[i].tgt;
            ex_flush_req  = vecs[i].flush;
            tick();
            check($sformatf("vec%0d pred_valid", i), {31'd0, pred_valid}, {31'd0, vecs[i].e_pv});
            if (vecs[i].chk) begin
                check($sformatf("vec%0d pred_taken", i), {31'd0, pred_taken},
                      {31'd0, vecs[i].e_pt});
                check($sformatf("vec%0d pred_target", i), pred_target, vecs[i].e_ptgt);
            end
            check($sformatf("vec%0d mispred_cnt", i), mispred_cnt, vecs[i].e_mis);
        end

        // Randomized traffic over a small PC pool so tags alias and entries hit.
        for (int c = 0; c < 3000; c++) begin
            rst_n         = !(c == 0 || $urandom_range(0, 299) == 0);
            if_req        = $urandom_range(0, 3) != 0;
            if_stall      = $urandom_range(0, 4) == 0;
            if_pc         = 32'h00400000 | ($urandom_range(0, 1) << 6) | ($urandom_range(0, 15) << 2);
            ex_is_jmp     = $urandom_range(0, 1) == 1;
            ex_pc         = 32'h00400000 | ($urandom_range(0, 1) << 6) | ($urandom_range(0, 15) << 2);
            ex_act_taken  = $urandom_range(0, 2) != 0;
            ex_act_target = $urandom;
            ex_flush_req  = $urandom_range(0, 3) == 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
